// File: rtl/reg_wb_arbiter.sv
// Write-port arbiter and RAW/WAW scoreboard for the 32x32b register file.
// Shares one write port between pipeline writeback and a queued long-latency return path.
module reg_wb_arbiter #(
  parameter int BITS       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [BITS-1:0] wb_data,
  input  logic            lu_issue,
  input  logic [4:0]      lu_issue_rd,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [BITS-1:0] lu_data,
  output logic            lu_ready,
  input  logic            id_valid,
  input  logic [4:0]      id_sr1,
  input  logic [4:0]      id_sr2,
  input  logic [4:0]      id_rd,
  output logic            rf_wen,
  output logic [4:0]      rf_rd,
  output logic [BITS-1:0] rf_data,
  output logic            stall,
  output logic [31:0]     busy_vec
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [4:0]      q_rd   [2];
  logic [BITS-1:0] q_data [2];
  logic            head;
  logic [1:0]      count;
  logic [31:0]     busy;
  logic [CW-1:0]   starve_cnt;

  logic        empty, full, tail, accept, enq, deq, clr_en, hazard, starve;
  logic [4:0]  clr_rd;
  logic [31:0] clr_mask, set_mask, busy_next;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign tail     = head ^ count[0];
  assign lu_ready = ~full & rst_n;
  assign accept   = lu_valid & lu_ready;
  assign busy_vec = busy;

  // Write-port priority: pipeline writeback, then queue head, then cut-through.
  always_comb begin
    rf_wen  = 1'b0;
    rf_rd   = '0;
    rf_data = '0;
    enq     = 1'b0;
    deq     = 1'b0;
    clr_en  = 1'b0;
    clr_rd  = '0;
    if (rst_n) begin
      if (wb_wen) begin
        rf_wen  = 1'b1;
        rf_rd   = wb_rd;
        rf_data = wb_data;
        enq     = accept;
      end else if (!empty) begin
        rf_wen  = 1'b1;
        rf_rd   = q_rd[head];
        rf_data = q_data[head];
        deq     = 1'b1;
        enq     = accept;
        clr_en  = 1'b1;
        clr_rd  = q_rd[head];
      end else if (lu_valid) begin
        rf_wen  = 1'b1;
        rf_rd   = lu_rd;
        rf_data = lu_data;
        clr_en  = 1'b1;
        clr_rd  = lu_rd;
      end
    end
  end

  // A newly issued destination wins over a same-cycle clear; x0 is never tracked.
  always_comb begin
    clr_mask  = clr_en ? (32'h1 << clr_rd) : 32'h0;
    set_mask  = lu_issue ? (32'h1 << lu_issue_rd) : 32'h0;
    busy_next = ((busy & ~clr_mask) | set_mask) & ~32'h1;
  end

  always_comb begin
    hazard = ((id_sr1 != 5'd0) & busy[id_sr1]) |
             ((id_sr2 != 5'd0) & busy[id_sr2]) |
             ((id_rd  != 5'd0) & busy[id_rd]);
    starve = (starve_cnt == CW'(STARVE_MAX));
    stall  = rst_n & id_valid & (hazard | starve);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head       <= 1'b0;
      count      <= 2'd0;
      busy       <= '0;
      starve_cnt <= '0;
    end else begin
      if (enq) begin
        q_rd[tail]   <= lu_rd;
        q_data[tail] <= lu_data;
      end
      if (deq) head <= ~head;
      count <= count + 2'(enq) - 2'(deq);
      busy  <= busy_next;
      // Counts cycles the queue loses to writeback; any dequeue or empty queue clears it.
      if (!empty && wb_wen) begin
        if (!starve) starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter and scoreboard for the 32x32b general-purpose register file. It shares the file's single write port between the in-order pipeline writeback stage and a long-latency unit (load/coprocessor return path), buffering long-latency results in a 2-entry queue. It tracks registers with pending long-latency writes and raises a decode stall on RAW/WAW hazards or write-port starvation. It sits between the WB stage and long-latency unit on one side and the register file write port (WEN/RD/DEST_DATA) on the other.

## Interface
- BITS, 32, data width (common parameter package)
- STARVE_MAX, 4, consecutive cycles a non-empty queue may lose arbitration before a starvation stall
- clk  in  1  global clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- wb_wen  in  1  pipeline writeback valid
- wb_rd  in  5  pipeline writeback destination
- wb_data  in  BITS  pipeline writeback data
- lu_issue  in  1  long-latency op issued this cycle (from decode, qualified by ~stall)
- lu_issue_rd  in  5  destination of issued op
- lu_valid  in  1  long-latency result valid
- lu_rd  in  5  result destination
- lu_data  in  BITS  result data
- lu_ready  out  1  result accepted when lu_valid & lu_ready
- id_valid  in  1  decode holds a valid instruction
- id_sr1, id_sr2, id_rd  in  5 each  decode source/destination addresses (0 = unused)
- rf_wen  out  1  register file write enable
- rf_rd  out  5  register file write address
- rf_data  out  BITS  register file write data
- stall  out  1  freeze fetch/decode
- busy_vec  out  32  scoreboard; bit 0 always 0

## Operation
- Scoreboard busy[31:0]: set on lu_issue & lu_issue_rd!=0; cleared when the long-latency path writes that rd to the file. Same-cycle set and clear of one bit: set wins. Bit 0 never set.
- Queue: 2-entry FIFO of {rd, data}. Enqueue on lu_valid & lu_ready when the result is not written directly. lu_ready = ~full & rst_n.
- Write-port priority, evaluated each cycle:
  - wb_wen=1: rf_* = wb_*; queue head held; lu result (if accepted) enqueued.
  - else queue non-empty: rf_* = head; dequeue; clear busy[head.rd].
  - else lu_valid: cut-through, rf_* = lu_*; clear busy[lu_rd]; no enqueue.
  - else rf_wen=0.
- rd=0 writes pass through with rf_wen as computed (file gates x0); they never touch busy.
- Starvation counter: increments each cycle queue non-empty and wb_wen=1; clears on any dequeue or queue empty; saturates at STARVE_MAX.
- stall = id_valid & (hazard | starve), where hazard = (id_sr1!=0 & busy[id_sr1]) | (id_sr2!=0 & busy[id_sr2]) | (id_rd!=0 & busy[id_rd]); starve = counter==STARVE_MAX. Starve holds until the queue dequeues (pipeline drains, wb_wen drops).
- Pipeline contract: lu results never target a register without busy set; bench flags violation.

## Timing
- rf_*, stall, lu_ready combinational from inputs and registered state (file samples on negedge, half cycle later).
- Cut-through result: written same cycle as lu_valid. Queued result: written first cycle with wb_wen=0 and it at head; minimum 1 cycle after enqueue.
- busy bit visible in busy_vec/stall the cycle after lu_issue; cleared the cycle after the file write.
- Hazard on a register written this cycle still stalls this cycle; released next cycle (file bypass covers forwarding).
- Reset (rst_n=0 at posedge): queue empty, busy=0, counter=0. While rst_n=0: rf_wen=0, lu_ready=0, stall=0. Reset mid-operation discards queued results and pending busy bits.
- Full queue with wb_wen=1 and lu_valid: lu_ready=0, result held by source.

## Test plan
- Cut-through: lu_issue rd=5; 3 cycles later lu_valid rd=5 data=0xDEADBEEF, wb_wen=0 -> rf_wen=1 rf_rd=5 same cycle; busy[5] set then 0 the cycle after.
- Conflict: wb_wen=1 rd=3 data=0x11 with lu_valid rd=7 data=0x22 -> rf writes x3; x7 enqueued; next cycle wb_wen=0 -> rf writes x7=0x22.
- RAW stall: busy[9]=1, id_valid id_sr2=9 -> stall=1 until cycle after x9 written; id_sr1=0 with busy clean -> stall=0.
- Back-pressure: wb_wen=1 continuous, 3 lu results -> 2 queued, lu_ready=0 on third; after STARVE_MAX=4 losing cycles stall=1 with id_valid; when wb_wen drops, queue drains in order, stall clears.
- Reset mid-operation: queue holding 2 entries, busy[4,6]=1, rst_n=0 one cycle -> rf_wen=0, lu_ready=0; after release busy_vec=0, queue empty, no spurious write.
- x0: lu_issue rd=0 -> busy_vec stays 0; id_sr1=0 never stalls.
